// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive stage that deserializes LSB-first frames from the SPI master into a local byte FIFO.
// Optional feature macro SPI_RX_ECHO_EN: miso echoes the previously completed byte back to the master.
//
// state | meaning
// IDLE  | cs inactive; sclk edges are ignored
// SHIFT | cs active; one mosi bit is sampled per sclk rise, and bytes complete every DATA_W rises
module spi_slave_rx #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clr_err
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_d;
    logic       cs_d;
    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       cs_rise;
    logic       cs_fall;

    state_t            state;
    state_t            state_next;
    logic              start;
    logic              stop;
    logic              shift_en;
    logic              byte_done;
    logic              frame_set;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] byte_word;
    logic              push_vld;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic              do_push;
    logic              do_pop;
    logic              ovf_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cs falling takes priority over a coincident sclk rise: the frame is over.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_rise) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_fall) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                    frame_set  = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    shift_en  = 1'b1;
                    byte_done = (bit_cnt == LAST_BIT);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_word          = sreg;
        byte_word[bit_cnt] = mosi_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            sreg      <= '0;
            push_vld  <= 1'b0;
            push_data <= '0;
        end else begin
            push_vld <= byte_done;
            if (byte_done) begin
                push_data <= byte_word;
            end
            if (start || stop) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                sreg    <= byte_word;
                bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the same cycle pops a byte.
    assign do_pop     = rd_en & ~empty;
    assign do_push    = push_vld & (~full | do_pop);
    assign ovf_set    = push_vld & full & ~do_pop;
    assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clr_err);
            frame_err <= frame_set | (frame_err & ~clr_err);
        end
    end

`ifdef SPI_RX_ECHO_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] echo;
    logic              miso_q;

    assign sclk_fall = ~sclk_s & sclk_d;

    // Echo captures every completed byte, including ones the FIFO drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo   <= '0;
            miso_q <= 1'b0;
        end else begin
            if (byte_done) begin
                echo <= byte_word;
            end
            if (state != SHIFT) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q <= echo[bit_cnt];
            end
        end
    end

    assign miso = miso_q & (state == SHIFT);
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: a queue-based reference FIFO and a separate pop monitor that compares every byte read out.
module tb_spi_slave_rx;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs = 1'b0;
    logic              mosi = 1'b0;
    logic              miso;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              overflow;
    logic              frame_err;
    logic              clr_err = 1'b0;

    spi_slave_rx #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model[$];
    logic [7:0] exp_q[$];
    bit         ovf_exp  = 1'b0;
    bit         ferr_exp = 1'b0;
    logic [7:0] last_exp = 8'h00;
    logic [7:0] last_sent = 8'h00;
    bit         first_in_window = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the next scoreboard byte one clk later.
    always @(posedge clk) begin
        if (!rst && rd_en && !empty) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_data: got 0x%0h, expected no pop", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_on();
        cs = 1'b1;
        first_in_window = 1'b1;
        wait_clk(6);
    endtask

    task automatic cs_off();
        wait_clk(4);
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic pop_begin();
        if (model.size() > 0) begin
            last_exp = model.pop_front();
            exp_q.push_back(last_exp);
        end
        rd_en = 1'b1;
    endtask

    task automatic pop();
        bit was_empty;
        was_empty = (model.size() == 0);
        pop_begin();
        wait_clk(1);
        rd_en = 1'b0;
        wait_clk(1);
        if (was_empty) check("rd_hold", rd_data, last_exp);
    endtask

    // sclk period is 8 clk; with pop_on_push the pop lands on the clk that pushes the byte.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit pop_on_push);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[i];
            wait_clk(4);
            sclk = 1'b1;
            got[i] = miso;
            if (pop_on_push && i == 7) begin
                wait_clk(3);
                pop_begin();
                wait_clk(1);
                rd_en = 1'b0;
            end else begin
                wait_clk(4);
            end
            sclk = 1'b0;
        end
        mosi = 1'b0;
        if (nbits == 8) begin
`ifdef SPI_RX_ECHO_EN
            if (!first_in_window) check("miso_echo", got, last_sent);
`else
            check("miso_zero", got, 0);
`endif
            last_sent = b;
            first_in_window = 1'b0;
            if (model.size() < DEPTH) model.push_back(b);
            else ovf_exp = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8, 1'b0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        ovf_exp = 1'b0;
        ferr_exp = 1'b0;
        wait_clk(1);
    endtask

    task automatic check_status(input string tag);
        wait_clk(2);
        check({tag, "_count"}, count, model.size());
        check({tag, "_empty"}, empty, model.size() == 0);
        check({tag, "_full"}, full, model.size() == DEPTH);
        check({tag, "_overflow"}, overflow, ovf_exp);
        check({tag, "_frame_err"}, frame_err, ferr_exp);
    endtask

    task automatic drain();
        while (model.size() > 0) pop();
    endtask

    initial begin
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check_status("reset");
        check("reset_rd_data", rd_data, 0);
        check("reset_miso", miso, 0);

        cs_on();
        send_byte(8'hA5);
        cs_off();
        check_status("single");
        pop();
        check_status("single_pop");

        cs_on();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check_status("burst_full");
        drain();
        pop();
        check_status("burst_drained");
        send_byte(8'h09);
        pop();
        cs_off();
        check_status("burst_wrap");

        cs_on();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'hFF);
        check_status("overflow");
        pop();
        pulse_clr();
        check_status("overflow_clr");
        drain();
        cs_off();

        cs_on();
        send_bits(8'h5B, 3, 1'b0);
        cs_off();
        ferr_exp = 1'b1;
        check_status("frame");
        cs_on();
        send_byte(8'h3C);
        cs_off();
        check_status("frame_next");
        pop();
        pulse_clr();
        check_status("frame_clr");

        cs_on();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
        send_bits(8'h77, 8, 1'b1);
        check_status("concurrent");
        drain();
        cs_off();

        cs_on();
        send_byte(8'h5A);
        send_byte(8'hC3);
        cs_off();
        drain();
        check_status("echo");

        for (int w = 0; w < 20; w++) begin
            int nb;
            nb = $urandom_range(1, 10);
            cs_on();
            for (int k = 0; k < nb; k++) begin
                send_byte(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 2) == 0) pop();
            end
            if ($urandom_range(0, 3) == 0) begin
                send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b0);
                ferr_exp = 1'b1;
            end
            cs_off();
            check_status("random");
            if ($urandom_range(0, 1) == 0) pulse_clr();
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        check_status("final");
        check("scoreboard_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receive stage directly downstream of the team's SPI master/FIFO transmitter. Consumes the master's mclk/mosi/cs stream, deserializes LSB-first bytes and buffers them in a local receive FIFO. A local consumer drains the FIFO through a read strobe. Transfer errors are reported through sticky overflow and framing flags.

Parameters:
DEPTH, 8, receive FIFO depth in bytes (power of 2)
AW, 3, FIFO address width, log2(DEPTH)
DATA_W, 8, bits per SPI frame

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
sclk  input  1  SPI clock from master, asynchronous to clk
cs  input  1  chip select from master, active-high
mosi  input  1  serial data from master
miso  output  1  serial data to master
rd_en  input  1  FIFO pop strobe
rd_data  output  DATA_W  popped byte, registered
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  AW+1  FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: byte dropped because FIFO was full
frame_err  output  1  sticky: cs dropped mid-byte
clr_err  input  1  clears overflow and frame_err

Behaviour:
- This block has one decided interface point: reset rst, asynchronous, active-high; clock clk.
- Reset values: miso=0, rd_data=0x00, empty=1, full=0, count=0, overflow=0, frame_err=0. Also cleared by reset: FSM=IDLE, bit_cnt=0, shift register=0, FIFO pointers=0.
- Synchronization: sclk, cs and mosi each pass through a 2-flop synchronizer.
- Edge detection: the block detects sclk rise and fall from the synchronized sclk and its delayed copy.
- Clock ratio: clk must be at least 4x the sclk frequency.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on synchronized cs rising; bit_cnt=0.
  - SHIFT, on each sclk rise: sreg[bit_cnt] <= mosi_s (LSB first), then bit_cnt++.
  - When bit_cnt is 7 at an sclk rise, the byte completes. It is pushed to the FIFO on the next clk. bit_cnt wraps to 0 and the FSM stays in SHIFT (back-to-back bytes, no gap required).
  - SHIFT -> IDLE on synchronized cs falling.
    - If bit_cnt != 0: the partial byte is discarded and frame_err is set.
    - If bit_cnt == 0: clean end, no error.
  - sclk edges in IDLE are ignored.
- Latency: empty deasserts at most 4 clk after the raw 8th sclk rising edge.
- FIFO push when full: the byte is dropped, overflow is set, and FIFO contents are unchanged.
- FIFO pop: when rd_en=1 and empty=0, rd_data is updated on the next clk (1-cycle latency).
  - rd_en while empty is ignored; rd_data holds its value.
- Simultaneous push and pop:
  - Full FIFO: both are performed, count is unchanged, overflow is not set.
  - Empty FIFO: only the push is performed.
- Pointers wrap modulo DEPTH.
- count, full and empty are registered and consistent in the same cycle.
- Sticky flags: clr_err clears both. If clr_err coincides with a new error event, set wins.
- cs bounce: cs re-asserting in the same cycle as the IDLE transition is picked up one cycle later (edge detect on the synchronized signal).

Optional Feature:
- Macro: SPI_RX_ECHO_EN.
- Defined: an echo register holds the last completed byte (reset 0x00). It is loaded at each byte completion, including bytes dropped by overflow.
  - On each sclk fall in SHIFT, miso <= echo[bit_cnt]. The master therefore sees byte N-1 while sending byte N.
  - miso is forced to 0 in IDLE.
- Undefined: miso is constant 0, and no echo logic is present.

Test Plan:
- After reset: cs high, send 0xA5 LSB-first, cs low -> empty=0, count=1. Pop -> rd_data=0xA5, empty=1, no flags set.
- Burst: cs held, send 0x01..0x08 back-to-back -> count=8, full=1. Pop all -> 0x01..0x08 in order, pointers wrap cleanly. Send 0x09 and pop -> 0x09.
- Overflow: fill 8 bytes, send 0xFF -> overflow=1, count stays 8, first pop=0x01. Pulse clr_err -> overflow=0.
- Framing: cs high, 3 sclk edges, cs low -> frame_err=1, count unchanged. Next full byte 0x3C is received correctly.
- Concurrency: while full, pop in the same cycle as a push completes -> count stays 8, overflow=0, newest byte is last out.
- With SPI_RX_ECHO_EN: send 0x5A then 0xC3 in one cs window -> miso during the second byte shifts out 0x5A LSB-first. Without the macro, miso stays 0 throughout.
